// File: rtl/mod5_down.sv
// Modulo-5 counter (4,3,2,1,0,4,...) with load, wrap pulse, load-error pulse and saturating wrap tally.
// One-edge latency on all outputs, no backpressure; define MOD5_DOWN_UPDN_EN to add the up_dn direction input.
module mod5_down #(
  parameter int RESET_VAL = 4,
  parameter int WRAP_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              load,
  input  logic [2:0]        load_val,
  input  logic              clr_wrap,
`ifdef MOD5_DOWN_UPDN_EN
  input  logic              up_dn,
`endif
  output logic [2:0]        out,
  output logic              tc,
  output logic              load_err,
  output logic [WRAP_W-1:0] wrap_cnt
);

  localparam logic [2:0] TOP     = 3'd4;
  localparam logic [2:0] RST_VAL = (RESET_VAL < 0 || RESET_VAL > 4) ? TOP : 3'(RESET_VAL);

  logic [2:0]        cnt_q, cnt_d;
  logic              tc_q, load_err_q;
  logic              wrap, load_err_d, count_up;
  logic [WRAP_W-1:0] wcnt_q, wcnt_d;

`ifdef MOD5_DOWN_UPDN_EN
  assign count_up = up_dn;
`else
  assign count_up = 1'b0;
`endif

  // Priority: load, then recovery from an unreachable value (5-7), then counting.
  always_comb begin
    cnt_d      = cnt_q;
    wrap       = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_val > TOP) begin
        cnt_d      = TOP;
        load_err_d = 1'b1;
      end else begin
        cnt_d = load_val;
      end
    end else if (cnt_q > TOP) begin
      cnt_d = TOP;
    end else if (en) begin
      if (count_up) begin
        if (cnt_q == TOP) begin
          cnt_d = 3'd0;
          wrap  = 1'b1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end else begin
        if (cnt_q == 3'd0) begin
          cnt_d = TOP;
          wrap  = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
    end
  end

  // Clear beats a coincident wrap; the tally sticks at all-ones.
  always_comb begin
    wcnt_d = wcnt_q;
    if (clr_wrap) begin
      wcnt_d = '0;
    end else if (wrap && (wcnt_q != '1)) begin
      wcnt_d = wcnt_q + WRAP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= RST_VAL;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
      wcnt_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      tc_q       <= wrap;
      load_err_q <= load_err_d;
      wcnt_q     <= wcnt_d;
    end
  end

  assign out      = cnt_q;
  assign tc       = tc_q;
  assign load_err = load_err_q;
  assign wrap_cnt = wcnt_q;

endmodule

// File: tb/tb_mod5_down.sv
// Directed bench for mod5_down: a modulo-arithmetic reference model checked every cycle, plus literal pins.
module tb_mod5_down;
  localparam int WW   = 2;
  localparam int MAXW = (1 << WW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          en = 1'b0;
  logic          load = 1'b0;
  logic [2:0]    load_val = 3'd0;
  logic          clr_wrap = 1'b0;
  logic          up_dn = 1'b0;
  logic [2:0]    out;
  logic          tc;
  logic          load_err;
  logic [WW-1:0] wrap_cnt;

  int checks = 0;
  int errors = 0;

  int m_out = 4;
  int m_tc  = 0;
  int m_le  = 0;
  int m_wc  = 0;

  mod5_down #(.RESET_VAL(4), .WRAP_W(WW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .clr_wrap (clr_wrap),
`ifdef MOD5_DOWN_UPDN_EN
    .up_dn    (up_dn),
`endif
    .out      (out),
    .tc       (tc),
    .load_err (load_err),
    .wrap_cnt (wrap_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_out = 4; m_tc = 0; m_le = 0; m_wc = 0;
  endtask

  task automatic model_step();
    int wrapped;
    int going_up;
    wrapped = 0;
    m_tc = 0;
    m_le = 0;
`ifdef MOD5_DOWN_UPDN_EN
    going_up = int'(up_dn);
`else
    going_up = 0;
`endif
    if (load) begin
      if (int'(load_val) <= 4) m_out = int'(load_val);
      else begin m_out = 4; m_le = 1; end
    end else if (m_out > 4) begin
      m_out = 4;
    end else if (en) begin
      if (going_up != 0) begin
        wrapped = (m_out == 4) ? 1 : 0;
        m_out = (m_out + 1) % 5;
      end else begin
        wrapped = (m_out == 0) ? 1 : 0;
        m_out = (m_out + 4) % 5;
      end
      m_tc = wrapped;
    end
    if (clr_wrap) m_wc = 0;
    else if (wrapped != 0 && m_wc < MAXW) m_wc = m_wc + 1;
  endtask

  task automatic compare_model();
    check("out", int'(out), m_out);
    check("tc", int'(tc), m_tc);
    check("load_err", int'(load_err), m_le);
    check("wrap_cnt", int'(wrap_cnt), m_wc);
  endtask

  // Model advances on the edge; DUT is sampled 2 time units later and new inputs are driven then.
  task automatic tick();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step();
    #2;
    compare_model();
  endtask

  initial begin
    int seq_out[10];
    int seq_tc[10];
    seq_out = '{3, 2, 1, 0, 4, 3, 2, 1, 0, 4};
    seq_tc  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    // 1: reset, then count 10 steps
    tick();
    tick();
    check("rst_out", int'(out), 4);
    check("rst_tc", int'(tc), 0);
    check("rst_load_err", int'(load_err), 0);
    check("rst_wrap_cnt", int'(wrap_cnt), 0);
    reset_n = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("seq_out", int'(out), seq_out[i]);
      check("seq_tc", int'(tc), seq_tc[i]);
    end
    check("seq_wrap_cnt", int'(wrap_cnt), 2);

    // 2: load paths
    load = 1'b1; load_val = 3'd2;
    tick();
    check("load2_out", int'(out), 2);
    check("load2_tc", int'(tc), 0);
    load_val = 3'd6;
    tick();
    check("load6_out", int'(out), 4);
    check("load6_err", int'(load_err), 1);
    load = 1'b0;
    tick();
    check("resume_out", int'(out), 3);
    check("resume_err", int'(load_err), 0);
    tick();
    check("resume2_out", int'(out), 2);

    // 3: hold, then recovery from an illegal value
    en = 1'b0;
    repeat (5) tick();
    check("hold_out", int'(out), 2);
    check("hold_wrap_cnt", int'(wrap_cnt), 2);
    check("hold_tc", int'(tc), 0);
    force dut.cnt_q = 3'd7;
    #1;
    release dut.cnt_q;
    m_out = 7;
    check("seu_out", int'(out), 7);
    tick();
    check("recover_out", int'(out), 4);
    check("recover_tc", int'(tc), 0);

    // 4: saturation, then clear coincident with a wrap
    en = 1'b1;
    repeat (25) tick();
    check("sat_wrap_cnt", int'(wrap_cnt), 3);
    check("sat_out", int'(out), 4);
    repeat (4) tick();
    check("pre_clr_out", int'(out), 0);
    clr_wrap = 1'b1;
    tick();
    check("clr_out", int'(out), 4);
    check("clr_tc", int'(tc), 1);
    check("clr_wrap_cnt", int'(wrap_cnt), 0);
    clr_wrap = 1'b0;
    repeat (5) tick();
    check("post_clr_wrap_cnt", int'(wrap_cnt), 1);
    repeat (3) tick();
    check("pre_rst_out", int'(out), 1);

    // 5: asynchronous reset between edges
    #1;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("arst_out", int'(out), 4);
    check("arst_tc", int'(tc), 0);
    check("arst_wrap_cnt", int'(wrap_cnt), 0);
    compare_model();
    tick();
    reset_n = 1'b1;
    tick();
    check("first_step_out", int'(out), 3);

`ifdef MOD5_DOWN_UPDN_EN
    // 6: up counting from 3, then reverse at 0
    up_dn = 1'b1;
    tick();
    check("up_out4", int'(out), 4);
    check("up_tc4", int'(tc), 0);
    tick();
    check("up_out0", int'(out), 0);
    check("up_tc0", int'(tc), 1);
    up_dn = 1'b0;
    tick();
    check("dn_out4", int'(out), 4);
    check("dn_tc4", int'(tc), 1);
    tick();
    check("dn_out3", int'(out), 3);
    check("dn_tc3", int'(tc), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod5_down.md
Name: mod5_down

Overview:
Modulo-5 down counter: sequence 4,3,2,1,0,4,...
- Decrementing counterpart to the team's mod-5 up counter.
- Adds count enable, synchronous load, a wrap (terminal-count) pulse and a saturating wrap tally.
- Used as a cascadable prescaler/timer stage in the counter family.

Parameters:
RESET_VAL, 4, value of out after reset; legal range 0-4.
WRAP_W, 8, width of wrap_cnt.

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  asynchronous, active-low reset.
en  input  1  count enable; one step per clk when high.
load  input  1  synchronous load strobe.
load_val  input  3  value loaded when load=1.
clr_wrap  input  1  synchronous clear of wrap_cnt.
out  output  3  current count, registered.
tc  output  1  registered one-cycle wrap pulse.
load_err  output  1  registered one-cycle pulse: out-of-range load.
wrap_cnt  output  WRAP_W  saturating count of wraps.

Behaviour:
Interface:
- One clock, clk.
- reset_n is asynchronous and active-low.
- Reset assertion acts immediately, with no clock required.

Reset values:
- out=RESET_VAL, tc=0, load_err=0, wrap_cnt=0.
- Release is sampled on clk; the first count step occurs on the first rising edge with reset_n=1 and en=1.

Priority per edge for out: reset > load > illegal-state recovery > en > hold.

Load:
- load=1 with load_val 0-4: out<=load_val.
- load=1 with load_val 5-7: out<=4 and load_err=1 for one cycle.
- load overrides en in the same cycle. No tc and no wrap_cnt change on a load cycle.

Count (en=1, load=0):
- out 4->3->2->1->0, then 0->4.
- The 0->4 transition is a wrap. tc=1 in the cycle after the edge that performs the wrap, i.e. concurrent with out==4.
- tc is high for exactly one cycle per wrap, even with en held high.

Hold:
- en=0: out holds, tc=0.

Illegal state:
- If out holds 5-7 (SEU or X-init), the next clk edge forces out<=4 regardless of en.
- No tc, no load_err in that case.

wrap_cnt:
- Increments by 1 on each wrap.
- Saturates at all-ones; no roll-over.
- clr_wrap=1 sets it to 0. If a wrap happens in the same cycle, the clear wins; the result is 0, but tc still pulses.
- load does not affect wrap_cnt.

Latency:
- out changes one edge after the enabling condition.
- tc and load_err are registered, so they align with the new out value.

Reset mid-operation:
- All outputs return to reset values immediately.
- Any pending tc or load_err pulse is dropped.

Optional Feature:
Macro: MOD5_DOWN_UPDN_EN.
Defined:
- Adds input up_dn (1 bit).
- up_dn=1: counts 0->1->2->3->4->0; the 4->0 transition is the wrap (tc, wrap_cnt).
- up_dn=0: down counting as above.
- Direction changes take effect on the next enabled edge; no wrap is generated by the change itself.
- Load, recovery and saturation rules are unchanged.
Undefined:
- up_dn port is absent; the block counts down only.

Test Plan:
1. Reset and count: reset_n=0 with RESET_VAL=4, then release, en=1 for 10 cycles -> out 4,3,2,1,0,4,3,2,1,0,4; tc high exactly on the 2 cycles out returns to 4; wrap_cnt=2.
2. Load paths: load=1, load_val=2, en=1 -> out=2, no tc. Then load_val=6 -> out=4, load_err one cycle. Then load=0 -> counting resumes 3,2.
3. Hold and illegal recovery: en=0 for 5 cycles -> out and wrap_cnt stable, tc=0. Then force out=7 -> next edge out=4, tc=0.
4. Saturation and clear: WRAP_W=2, run 5 wraps -> wrap_cnt stops at 3. clr_wrap=1 coincident with a wrap -> wrap_cnt=0, tc=1.
5. Async reset mid-count: drop reset_n between clock edges while out=1 -> out=4, tc=0, wrap_cnt=0 immediately, before the next clk edge.
6. With MOD5_DOWN_UPDN_EN: up_dn=1 from 3 -> 4,0 with tc on 0. Switch to up_dn=0 while out=0 -> 4 with tc, then 3.
